// File: rtl/mystic_divider.sv
`default_nettype none
// ============================================================================
// Module  : mystic_divider
// Purpose : Iterative restoring radix-2 divider (DIV/DIVU/REM/REMU), one
//           quotient bit per clock. Optional macro MYSTIC_DIV_EARLY_OUT_EN
//           skips the iteration phase for divide-by-zero and unit divisors.
// Revision: 1.0 - initial release
// ============================================================================
module mystic_divider #(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            div_is_signed_i,
    input  logic            div_enable_i,
    input  logic [XLEN-1:0] div_dividend_i,
    input  logic [XLEN-1:0] div_divisor_i,
    output logic [XLEN-1:0] div_quotient_o,
    output logic [XLEN-1:0] div_remainder_o,
    output logic            div_ready_o,
    output logic            div_busy_o
);

    localparam int              c_CNT_W = $clog2(XLEN) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [XLEN-1:0]    r_dvd_orig;
    logic [XLEN-1:0]    r_dvs_mag;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_q;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_dz;
    logic [XLEN-1:0]    r_quot;
    logic [XLEN-1:0]    r_remd;
    logic               r_ready;
    logic               r_busy;

    logic               w_dvd_neg;
    logic               w_dvs_neg;
    logic [XLEN-1:0]    w_dvd_mag;
    logic [XLEN-1:0]    w_dvs_mag;
    logic               w_dz;
    logic               w_early;
    logic [XLEN:0]      w_trial;

    assign w_dvd_neg = div_is_signed_i & div_dividend_i[XLEN-1];
    assign w_dvs_neg = div_is_signed_i & div_divisor_i[XLEN-1];
    assign w_dvd_mag = w_dvd_neg ? (-div_dividend_i) : div_dividend_i;
    assign w_dvs_mag = w_dvs_neg ? (-div_divisor_i) : div_divisor_i;
    assign w_dz      = (div_divisor_i == '0);

`ifdef MYSTIC_DIV_EARLY_OUT_EN
    // A unit divisor leaves the dividend magnitude in r_q and zero in r_rem,
    // which is already the final answer before sign correction.
    assign w_early = w_dz | (w_dvs_mag == XLEN'(1));
`else
    assign w_early = 1'b0;
`endif

    // 65-bit trial subtract: the shifted remainder can exceed XLEN bits.
    assign w_trial = {r_rem, r_q[XLEN-1]} - {1'b0, r_dvs_mag};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (div_enable_i) begin
                    w_state_next = w_early ? S_FIX : S_DIV;
                end
            end
            S_DIV: begin
                if (r_cnt == c_LAST) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_dvd_orig <= '0;
            r_dvs_mag  <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_dz       <= 1'b0;
            r_quot     <= '0;
            r_remd     <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (div_enable_i) begin
                        r_dvd_orig <= div_dividend_i;
                        r_dvs_mag  <= w_dvs_mag;
                        r_q        <= w_dvd_mag;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        r_q_neg    <= w_dvd_neg ^ w_dvs_neg;
                        r_r_neg    <= w_dvd_neg;
                        r_dz       <= w_dz;
                        r_busy     <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!w_trial[XLEN]) begin
                        r_rem <= w_trial[XLEN-1:0];
                        r_q   <= {r_q[XLEN-2:0], 1'b1};
                    end else begin
                        r_rem <= {r_rem[XLEN-2:0], r_q[XLEN-1]};
                        r_q   <= {r_q[XLEN-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    if (r_dz) begin
                        r_quot <= '1;
                        r_remd <= r_dvd_orig;
                    end else begin
                        r_quot <= r_q_neg ? (-r_q)   : r_q;
                        r_remd <= r_r_neg ? (-r_rem) : r_rem;
                    end
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign div_quotient_o  = r_quot;
    assign div_remainder_o = r_remd;
    assign div_ready_o     = r_ready;
    assign div_busy_o      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mystic_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_mystic_divider
// Purpose : Directed self-checking bench for mystic_divider.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mystic_divider;

    localparam int c_XLEN  = 64;
    localparam int c_FULL  = 65;
`ifdef MYSTIC_DIV_EARLY_OUT_EN
    localparam int c_SHORT = 1;
`else
    localparam int c_SHORT = 65;
`endif

    logic              clk;
    logic              rstn;
    logic              sgn;
    logic              en;
    logic [c_XLEN-1:0] dvd;
    logic [c_XLEN-1:0] dvs;
    logic [c_XLEN-1:0] quo;
    logic [c_XLEN-1:0] rem;
    logic              rdy;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    mystic_divider #(.XLEN(c_XLEN)) dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .div_is_signed_i (sgn),
        .div_enable_i    (en),
        .div_dividend_i  (dvd),
        .div_divisor_i   (dvs),
        .div_quotient_o  (quo),
        .div_remainder_o (rem),
        .div_ready_o     (rdy),
        .div_busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request, return at the negedge following the accept edge.
    task automatic start_op(input logic s, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        sgn = s; dvd = a; dvs = b; en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en  = 1'b0;
        dvd = {$urandom, $urandom};
        dvs = {$urandom, $urandom};
        sgn = 1'($urandom);
    endtask

    // Count edges until ready is seen; lat > 200 means it never came.
    task automatic wait_ready(input int start, output int lat, output bit busy_gap);
        lat      = start;
        busy_gap = 1'b0;
        while (lat <= 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rdy) break;
            if (!busy) busy_gap = 1'b1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b0; sgn = 1'b0; dvd = '0; dvs = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (quo !== 64'd0) begin n_bad++; $display("FAIL reset_quo: got %h want 0", quo); end
        n_cmp++; if (rem !== 64'd0) begin n_bad++; $display("FAIL reset_rem: got %h want 0", rem); end
        n_cmp++; if (rdy !== 1'b0)  begin n_bad++; $display("FAIL reset_rdy: got %b want 0", rdy); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rstn = 1'b1;
    endtask

    task automatic test_unsigned();
        int lat; bit gap;
        start_op(1'b0, 64'd100, 64'd7);
        wait_ready(0, lat, gap);
        n_cmp++; if (lat !== c_FULL) begin n_bad++; $display("FAIL u100_7_lat: got %0d want %0d", lat, c_FULL); end
        n_cmp++; if (gap !== 1'b0) begin n_bad++; $display("FAIL u100_7_busy: got gap %b want 0", gap); end
        n_cmp++; if (quo !== 64'd14) begin n_bad++; $display("FAIL u100_7_q: got %h want %h", quo, 64'd14); end
        n_cmp++; if (rem !== 64'd2)  begin n_bad++; $display("FAIL u100_7_r: got %h want %h", rem, 64'd2); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL u100_7_busy_rdy: got %b want 0", busy); end
        @(negedge clk);
        n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL u100_7_pulse: got %b want 0", rdy); end
        n_cmp++; if (quo !== 64'd14) begin n_bad++; $display("FAIL u100_7_hold: got %h want %h", quo, 64'd14); end
    endtask

    task automatic test_signed();
        int lat; bit gap;
        start_op(1'b1, -64'sd7, 64'd2);
        wait_ready(0, lat, gap);
        n_cmp++; if (lat !== c_FULL) begin n_bad++; $display("FAIL sm7_2_lat: got %0d want %0d", lat, c_FULL); end
        n_cmp++; if (quo !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_bad++; $display("FAIL sm7_2_q: got %h want fffffffffffffffd", quo); end
        n_cmp++; if (rem !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL sm7_2_r: got %h want ffffffffffffffff", rem); end
        start_op(1'b1, 64'd7, -64'sd2);
        wait_ready(0, lat, gap);
        n_cmp++; if (quo !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_bad++; $display("FAIL s7_m2_q: got %h want fffffffffffffffd", quo); end
        n_cmp++; if (rem !== 64'd1) begin n_bad++; $display("FAIL s7_m2_r: got %h want 1", rem); end
    endtask

    task automatic test_div_zero();
        int lat; bit gap;
        start_op(1'b0, 64'd5, 64'd0);
        wait_ready(0, lat, gap);
        n_cmp++; if (lat !== c_SHORT) begin n_bad++; $display("FAIL u5_0_lat: got %0d want %0d", lat, c_SHORT); end
        n_cmp++; if (quo !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL u5_0_q: got %h want ffffffffffffffff", quo); end
        n_cmp++; if (rem !== 64'd5) begin n_bad++; $display("FAIL u5_0_r: got %h want 5", rem); end
        start_op(1'b1, -64'sd5, 64'd0);
        wait_ready(0, lat, gap);
        n_cmp++; if (lat !== c_SHORT) begin n_bad++; $display("FAIL sm5_0_lat: got %0d want %0d", lat, c_SHORT); end
        n_cmp++; if (quo !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL sm5_0_q: got %h want ffffffffffffffff", quo); end
        n_cmp++; if (rem !== 64'hFFFF_FFFF_FFFF_FFFB) begin n_bad++; $display("FAIL sm5_0_r: got %h want fffffffffffffffb", rem); end
    endtask

    task automatic test_overflow();
        int lat; bit gap;
        start_op(1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_ready(0, lat, gap);
        n_cmp++; if (lat !== c_SHORT) begin n_bad++; $display("FAIL ovf_lat: got %0d want %0d", lat, c_SHORT); end
        n_cmp++; if (quo !== 64'h8000_0000_0000_0000) begin n_bad++; $display("FAIL ovf_q: got %h want 8000000000000000", quo); end
        n_cmp++; if (rem !== 64'd0) begin n_bad++; $display("FAIL ovf_r: got %h want 0", rem); end
        start_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000);
        wait_ready(0, lat, gap);
        n_cmp++; if (quo !== 64'hFFFF_FFFF) begin n_bad++; $display("FAIL umax_q: got %h want 00000000ffffffff", quo); end
        n_cmp++; if (rem !== 64'hFFFF_FFFF) begin n_bad++; $display("FAIL umax_r: got %h want 00000000ffffffff", rem); end
    endtask

    task automatic test_enable_while_busy();
        int lat; bit gap;
        start_op(1'b0, 64'd100, 64'd7);
        repeat (9) @(negedge clk);
        sgn = 1'b0; dvd = 64'd9; dvs = 64'd3; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_ready(10, lat, gap);
        n_cmp++; if (lat !== c_FULL) begin n_bad++; $display("FAIL ewb_lat: got %0d want %0d", lat, c_FULL); end
        n_cmp++; if (quo !== 64'd14) begin n_bad++; $display("FAIL ewb_q: got %h want %h", quo, 64'd14); end
        n_cmp++; if (rem !== 64'd2)  begin n_bad++; $display("FAIL ewb_r: got %h want %h", rem, 64'd2); end
    endtask

    task automatic test_reset_mid();
        int lat; bit gap; bit saw_rdy;
        start_op(1'b0, 64'd100, 64'd7);
        repeat (29) @(negedge clk);
        rstn = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_cmp++; if (quo !== 64'd0) begin n_bad++; $display("FAIL rmid_q: got %h want 0", quo); end
        n_cmp++; if (rem !== 64'd0) begin n_bad++; $display("FAIL rmid_r: got %h want 0", rem); end
        saw_rdy = 1'b0;
        repeat (2) begin @(negedge clk); if (rdy) saw_rdy = 1'b1; end
        rstn = 1'b1;
        repeat (70) begin @(negedge clk); if (rdy || busy) saw_rdy = 1'b1; end
        n_cmp++; if (saw_rdy !== 1'b0) begin n_bad++; $display("FAIL rmid_noready: got %b want 0", saw_rdy); end
        start_op(1'b0, 64'd9, 64'd3);
        wait_ready(0, lat, gap);
        n_cmp++; if (quo !== 64'd3) begin n_bad++; $display("FAIL rmid_9_3_q: got %h want 3", quo); end
        n_cmp++; if (rem !== 64'd0) begin n_bad++; $display("FAIL rmid_9_3_r: got %h want 0", rem); end
    endtask

    task automatic test_back_to_back();
        int lat; bit gap;
        @(negedge clk);
        sgn = 1'b0; dvd = 64'd100; dvs = 64'd7; en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_ready(0, lat, gap);
        n_cmp++; if (lat !== c_FULL) begin n_bad++; $display("FAIL b2b_lat1: got %0d want %0d", lat, c_FULL); end
        n_cmp++; if (quo !== 64'd14) begin n_bad++; $display("FAIL b2b_q1: got %h want %h", quo, 64'd14); end
        dvd = 64'd9; dvs = 64'd3;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_pulse: got %b want 0", rdy); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: got %b want 1", busy); end
        wait_ready(0, lat, gap);
        n_cmp++; if (lat !== c_FULL) begin n_bad++; $display("FAIL b2b_lat2: got %0d want %0d", lat, c_FULL); end
        n_cmp++; if (quo !== 64'd3) begin n_bad++; $display("FAIL b2b_q2: got %h want 3", quo); end
        n_cmp++; if (rem !== 64'd0) begin n_bad++; $display("FAIL b2b_r2: got %h want 0", rem); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_enable_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
